// File: rtl/wm8731_cfg_sequencer_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: register map,
// fixed init data, sequence/state enums and control-word packing.
package wm8731_pkg;

    localparam logic [6:0] R0  = 7'h00;
    localparam logic [6:0] R2  = 7'h02;
    localparam logic [6:0] R4  = 7'h04;
    localparam logic [6:0] R5  = 7'h05;
    localparam logic [6:0] R6  = 7'h06;
    localparam logic [6:0] R7  = 7'h07;
    localparam logic [6:0] R8  = 7'h08;
    localparam logic [6:0] R9  = 7'h09;
    localparam logic [6:0] R15 = 7'h0F;

    localparam logic [8:0] D_RESET   = 9'h000;
    localparam logic [8:0] D_PWR     = 9'h002;
    localparam logic [8:0] D_APATH   = 9'h012;
    localparam logic [8:0] D_DPATH   = 9'h000;
    localparam logic [8:0] D_IFACE   = 9'h002;
    localparam logic [8:0] D_LIN     = 9'h117;
    localparam logic [8:0] D_ACT_ON  = 9'h001;
    localparam logic [8:0] D_ACT_OFF = 9'h000;

    localparam int INIT_LEN = 9;
    localparam int RATE_LEN = 3;

    typedef enum logic [1:0] {SEQ_INIT, SEQ_RATE, SEQ_GAIN} seq_e;
    typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, IDLE, ERROR} state_e;

    function automatic logic [15:0] mk_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/wm8731_cfg_sequencer_if.sv
// Word handshake between the sequencer (master) and the external 2-wire byte engine.
interface wm8731_cfg_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_word;
    logic        cmd_done;
    logic        cmd_ack;

    modport master (output cmd_valid, cmd_word, input cmd_ready, cmd_done, cmd_ack);
    modport slave  (input cmd_valid, cmd_word, output cmd_ready, cmd_done, cmd_ack);
endinterface

// File: rtl/wm8731_cfg_sequencer_rom.sv
// Control-word table: maps (sequence, index, rate, gain) to the 16-bit word and
// flags the final word of each sequence.
module wm8731_cfg_rom
    import wm8731_pkg::*;
(
    input  seq_e        seq,
    input  logic [3:0]  idx,
    input  logic [3:0]  rate_q,
    input  logic [5:0]  gain_q,
    output logic [15:0] word,
    output logic        last
);
    logic [8:0] gain_data;
    logic [8:0] rate_data;

    // LRHPBOTH=1, LZCEN=0, HPVOL={1'b1, gain}
    assign gain_data = {1'b1, 1'b0, 1'b1, gain_q};
    assign rate_data = {3'b000, rate_q, 2'b00};

    always_comb begin
        word = 16'h0000;
        last = 1'b0;
        case (seq)
            SEQ_INIT: begin
                last = (idx == 4'(INIT_LEN - 1));
                case (idx)
                    4'd0:    word = mk_word(R15, D_RESET);
                    4'd1:    word = mk_word(R6,  D_PWR);
                    4'd2:    word = mk_word(R4,  D_APATH);
                    4'd3:    word = mk_word(R5,  D_DPATH);
                    4'd4:    word = mk_word(R7,  D_IFACE);
                    4'd5:    word = mk_word(R0,  D_LIN);
                    4'd6:    word = mk_word(R2,  gain_data);
                    4'd7:    word = mk_word(R8,  rate_data);
                    4'd8:    word = mk_word(R9,  D_ACT_ON);
                    default: word = 16'h0000;
                endcase
            end
            SEQ_RATE: begin
                last = (idx == 4'(RATE_LEN - 1));
                case (idx)
                    4'd0:    word = mk_word(R9, D_ACT_OFF);
                    4'd1:    word = mk_word(R8, rate_data);
                    default: word = mk_word(R9, D_ACT_ON);
                endcase
            end
            default: begin
                last = 1'b1;
                word = mk_word(R2, gain_data);
            end
        endcase
    end
endmodule

// File: rtl/wm8731_cfg_sequencer.sv
// WM8731 configuration sequencer: power-up wait, fixed init, then coalesced
// sample-rate / headphone-gain updates with nack retry.
//   state | meaning
//   PWRUP | waiting POWERUP_CYCLES after reset
//   ISSUE | presenting cmd_word, waiting for ready
//   WAIT  | word accepted, waiting for done/ack
//   IDLE  | no sequence active, arbitrate pending updates
//   ERROR | retries exhausted, dead until reset
module wm8731_cfg_sequencer
    import wm8731_pkg::*;
#(
    parameter int         POWERUP_CYCLES = 1024,
    parameter int         MAX_RETRY      = 3,
    parameter logic [3:0] DEFAULT_RATE   = 4'h0,
    parameter logic [5:0] DEFAULT_GAIN   = 6'd57
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_rate,
    input  logic [3:0]                    rate,
    input  logic                          wr_gain,
    input  logic [5:0]                    gain,
    wm8731_cfg_sequencer_if.master        cmd,
    output logic                          init_done,
    output logic                          busy,
    output logic                          codec_active,
    output logic                          error
);
    localparam int PW = $clog2(POWERUP_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e        state_q, state_d;
    seq_e          seq_q, seq_d;
    logic [3:0]    idx_q, idx_d;
    logic [PW-1:0] pwr_cnt_q;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    rate_q, snap_rate_q, snap_rate_d, rom_rate;
    logic [5:0]    gain_q, snap_gain_q, snap_gain_d, rom_gain;
    logic          rate_pend_q, gain_pend_q;
    logic [15:0]   word_q, rom_word;
    logic          last_q, rom_last;
    logic          load_word, start_rate, start_gain;
    logic          active_d, init_done_d, pwr_tc;

    assign pwr_tc = (pwr_cnt_q == PW'(POWERUP_CYCLES - 1));

    // Init follows the live settings; update sequences use the values frozen at start.
    assign rom_rate = (seq_d == SEQ_INIT) ? rate_q : snap_rate_d;
    assign rom_gain = (seq_d == SEQ_INIT) ? gain_q : snap_gain_d;

    wm8731_cfg_rom u_rom (
        .seq    (seq_d),
        .idx    (idx_d),
        .rate_q (rom_rate),
        .gain_q (rom_gain),
        .word   (rom_word),
        .last   (rom_last)
    );

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        snap_rate_d = snap_rate_q;
        snap_gain_d = snap_gain_q;
        load_word   = 1'b0;
        start_rate  = 1'b0;
        start_gain  = 1'b0;
        active_d    = codec_active;
        init_done_d = init_done;
        case (state_q)
            PWRUP: if (pwr_tc) begin
                state_d   = ISSUE;
                seq_d     = SEQ_INIT;
                idx_d     = '0;
                load_word = 1'b1;
            end
            ISSUE: if (cmd.cmd_ready) state_d = WAIT;
            WAIT: if (cmd.cmd_done) begin
                if (cmd.cmd_ack) begin
                    retry_d = '0;
                    if (word_q[15:9] == R9) active_d = word_q[0];
                    if (last_q) begin
                        state_d = IDLE;
                        if (seq_q == SEQ_INIT) init_done_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        state_d   = ISSUE;
                        load_word = 1'b1;
                    end
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    state_d = ERROR;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            IDLE: if (rate_pend_q || gain_pend_q) begin
                start_rate  = rate_pend_q;
                start_gain  = !rate_pend_q;
                seq_d       = rate_pend_q ? SEQ_RATE : SEQ_GAIN;
                idx_d       = '0;
                snap_rate_d = rate_q;
                snap_gain_d = gain_q;
                state_d     = ISSUE;
                load_word   = 1'b1;
            end
            ERROR: state_d = ERROR;
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= PWRUP;
            seq_q        <= SEQ_INIT;
            idx_q        <= '0;
            pwr_cnt_q    <= '0;
            retry_q      <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            rate_q       <= DEFAULT_RATE;
            gain_q       <= DEFAULT_GAIN;
            snap_rate_q  <= DEFAULT_RATE;
            snap_gain_q  <= DEFAULT_GAIN;
            rate_pend_q  <= 1'b0;
            gain_pend_q  <= 1'b0;
            init_done    <= 1'b0;
            codec_active <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            snap_rate_q  <= snap_rate_d;
            snap_gain_q  <= snap_gain_d;
            init_done    <= init_done_d;
            codec_active <= active_d;
            if (state_q == PWRUP) pwr_cnt_q <= pwr_cnt_q + 1'b1;
            if (load_word) begin
                word_q <= rom_word;
                last_q <= rom_last;
            end
            // A strobe on the start cycle wins over the clear so it is not lost.
            if (state_q != ERROR) begin
                if (wr_rate) begin
                    rate_q      <= rate;
                    rate_pend_q <= 1'b1;
                end else if (start_rate) begin
                    rate_pend_q <= 1'b0;
                end
                if (wr_gain) begin
                    gain_q      <= gain;
                    gain_pend_q <= 1'b1;
                end else if (start_gain) begin
                    gain_pend_q <= 1'b0;
                end
            end
        end
    end

    assign cmd.cmd_valid = (state_q == ISSUE);
    assign cmd.cmd_word  = word_q;
    assign busy          = (state_q != IDLE);
    assign error         = (state_q == ERROR);

endmodule
